// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: LSU state encoding, funct3 access codes and bus defaults
package riscv_lsu_pkg;
  localparam int LSU_XLEN = 32;
  localparam int LSU_BUS_TIMEOUT = 16;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP, LSU_DONE} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: store lane formatting, load extraction/extension, access legality
// we_i/funct3_i/addr_i describe the access; wr_data_i is rs2, rdata_i the bus word.
// be_o/wr_data_o drive the bus, rd_data_o is the extended load, bad_o flags misaligned/illegal.
module riscv_lsu_align import riscv_lsu_pkg::*; #(
  parameter int XLEN = LSU_XLEN
) (
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            bad_o
);
  logic illegal, misaligned, is_b, is_h;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign is_b = funct3_i[1:0] == 2'b00;
  assign is_h = funct3_i[1:0] == 2'b01;
  // Unsigned variants exist only for loads; stores with funct3[2] set are illegal.
  assign illegal = !(funct3_i inside {F3_B, F3_H, F3_W} || (!we_i && funct3_i inside {F3_BU, F3_HU}));
  assign misaligned = (is_h && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i != 2'b00);
  assign bad_o = illegal | misaligned;
  assign be_o = !we_i ? 4'b1111 : is_b ? 4'b0001 << addr_i : is_h ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;
  assign wr_data_o = is_b ? {4{wr_data_i[7:0]}} : is_h ? {2{wr_data_i[15:0]}} : wr_data_i;
  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
  assign rd_data_o = is_b ? {{24{byte_v[7] & ~funct3_i[2]}}, byte_v}
                   : is_h ? {{16{half_v[15] & ~funct3_i[2]}}, half_v}
                   : rdata_i;
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit bridging the core memory port to a valid/ready data bus
// Core side: i_lsu_req/we/funct3/addr/wr_data in; o_lsu_rd_data/done/err/stall out.
// Bus side: o_bus_valid/we/addr/be/wr_data out with i_bus_ready; i_bus_rvalid/rdata return.
module riscv_lsu import riscv_lsu_pkg::*; #(
  parameter int XLEN        = LSU_XLEN,
  parameter int BUS_TIMEOUT = LSU_BUS_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_req,
  input  logic            i_lsu_we,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wr_data,
  output logic [XLEN-1:0] o_lsu_rd_data,
  output logic            o_lsu_done,
  output logic            o_lsu_err,
  output logic            o_lsu_stall,
  output logic            o_bus_valid,
  input  logic            i_bus_ready,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_be,
  output logic [XLEN-1:0] o_bus_wr_data,
  input  logic            i_bus_rvalid,
  input  logic [XLEN-1:0] i_bus_rdata
);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  lsu_state_e state_q, state_d;
  logic we_q, err_q, err_d, idle, in_req, in_done, bad, timeout;
  logic [2:0] f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d, fmt_wdata, rd_ext;
  logic [3:0] fmt_be;
  logic [CW-1:0] cnt_q, cnt_d;
  assign idle = state_q == LSU_IDLE;
  assign in_req = state_q == LSU_REQ;
  assign in_done = state_q == LSU_DONE;
  assign timeout = cnt_q >= CW'(BUS_TIMEOUT - 1);
  // In IDLE the incoming request is checked for legality before it is latched;
  // afterwards the latched copy drives formatting so the bus fields stay stable.
  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .we_i      (idle ? i_lsu_we : we_q),
    .funct3_i  (idle ? i_lsu_funct3 : f3_q),
    .addr_i    (idle ? i_lsu_addr[1:0] : addr_q[1:0]),
    .wr_data_i (idle ? i_lsu_wr_data : wdata_q),
    .rdata_i   (i_bus_rdata),
    .be_o      (fmt_be),
    .wr_data_o (fmt_wdata),
    .rd_data_o (rd_ext),
    .bad_o     (bad)
  );
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    case (state_q)
      LSU_IDLE: if (i_lsu_req) begin
        err_d = bad;
        rdata_d = '0;
        cnt_d = '0;
        state_d = bad ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 1'b1;
        state_d = i_bus_ready ? (we_q ? LSU_DONE : LSU_RESP) : timeout ? LSU_DONE : LSU_REQ;
        err_d = !i_bus_ready && timeout;
      end
      LSU_RESP: begin
        cnt_d = cnt_q + 1'b1;
        rdata_d = i_bus_rvalid ? rd_ext : rdata_q;
        state_d = (i_bus_rvalid || timeout) ? LSU_DONE : LSU_RESP;
        err_d = !i_bus_rvalid && timeout;
      end
      default: state_d = LSU_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= LSU_IDLE;
      err_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      if (idle && i_lsu_req) begin
        we_q <= i_lsu_we;
        f3_q <= i_lsu_funct3;
        addr_q <= i_lsu_addr;
        wdata_q <= i_lsu_wr_data;
      end
    end
  // Bus fields are zero outside REQ so reset clears every output at once.
  assign o_bus_valid = in_req;
  assign o_bus_we = in_req & we_q;
  assign o_bus_addr = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign o_bus_be = in_req ? fmt_be : 4'b0000;
  assign o_bus_wr_data = in_req ? fmt_wdata : '0;
  assign o_lsu_done = in_done;
  assign o_lsu_err = in_done & err_q;
  assign o_lsu_rd_data = in_done ? rdata_q : '0;
  assign o_lsu_stall = !i_rst && ((idle && i_lsu_req) || in_req || state_q == LSU_RESP);
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and randomized checks of riscv_lsu against a behavioural model
module tb_riscv_lsu;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic lsu_req = 1'b0, lsu_we = 1'b0;
  logic [2:0] lsu_f3 = '0;
  logic [31:0] lsu_addr = '0, lsu_wd = '0, lsu_rd;
  logic lsu_done, lsu_err, lsu_stall;
  logic bus_valid, bus_ready = 1'b0, bus_we, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wd, bus_rdata = '0;
  logic [3:0] bus_be;
  int checks = 0, errors = 0;
  riscv_lsu #(.XLEN(32), .BUS_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_funct3(lsu_f3),
    .i_lsu_addr(lsu_addr), .i_lsu_wr_data(lsu_wd), .o_lsu_rd_data(lsu_rd), .o_lsu_done(lsu_done),
    .o_lsu_err(lsu_err), .o_lsu_stall(lsu_stall), .o_bus_valid(bus_valid), .i_bus_ready(bus_ready),
    .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be), .o_bus_wr_data(bus_wd),
    .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, bus_valid}, 0);
    chk({tag, "_done"}, {31'd0, lsu_done}, 0);
    chk({tag, "_err"}, {31'd0, lsu_err}, 0);
    chk({tag, "_stall"}, {31'd0, lsu_stall}, 0);
    chk({tag, "_rd"}, lsu_rd, 0);
    chk({tag, "_bus"}, bus_addr | bus_wd | {28'd0, bus_be} | {31'd0, bus_we}, 0);
  endtask
  // One instruction: rdly = cycles with valid before ready, vdly = RESP cycles before rvalid.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mem, input int rdly, input int vdly);
    int sz, lat, st, nv, rn, exp_lat, exp_nv;
    logic legal, tmo, acc, done, rdy_prev;
    logic [31:0] exp_be, exp_wd, exp_rd, lane;
    sz = 1 << (f3 % 4);
    legal = ((f3 <= 2) || (!we && (f3 == 4 || f3 == 5))) && (a % sz == 0);
    tmo = legal && rdly >= TO;
    exp_be = !we ? 15 : sz == 1 ? 1 << (a % 4) : sz == 2 ? 3 << (a % 4) : 15;
    exp_wd = sz == 1 ? (wd & 255) * 32'h01010101 : sz == 2 ? (wd & 65535) * 32'h00010001 : wd;
    lane = sz == 4 ? mem : (mem >> (8 * (a % 4))) & ((sz == 1) ? 32'hFF : 32'hFFFF);
    exp_rd = lane;
    if (f3 == 0 && lane >= 128) exp_rd = lane - 256;
    if (f3 == 1 && lane >= 32768) exp_rd = lane - 65536;
    if (!legal || we || tmo) exp_rd = 0;
    exp_lat = !legal ? 2 : tmo ? TO + 2 : we ? rdly + 3 : rdly + vdly + 4;
    exp_nv = !legal ? 0 : tmo ? TO : rdly + 1;
    lsu_req = 1'b1; lsu_we = we; lsu_f3 = f3; lsu_addr = a; lsu_wd = wd; bus_rdata = mem;
    #1;
    lat = 1; st = 0; nv = 0; rn = 0; acc = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (lsu_done) begin
        done = 1'b1;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        chk("done_err", {31'd0, lsu_err}, {31'd0, !legal || tmo});
        chk("done_rd", lsu_rd, exp_rd);
        chk("latency", lat, exp_lat);
        chk("stall_cycles", st, exp_lat - 1);
        chk("valid_cycles", nv, exp_nv);
        chk("done_valid", {31'd0, bus_valid}, 0);
      end else begin
        if (lsu_stall) st++;
        if (bus_valid) begin
          nv++;
          chk("bus_addr", bus_addr, a & ~32'd3);
          chk("bus_we", {31'd0, bus_we}, {31'd0, we});
          chk("bus_be", {28'd0, bus_be}, exp_be);
          if (we) chk("bus_wd", bus_wd, exp_wd);
        end
        bus_ready = bus_valid && nv > rdly;
        if (acc) rn++;
        bus_rvalid = acc && rn > vdly;
        rdy_prev = bus_ready;
        tick();
        lat++;
        if (rdy_prev && !we) acc = 1'b1;
      end
    end
    chk("done_seen", {31'd0, done}, 1);
    lsu_req = 1'b0;
    tick();
    chk("post_done", {30'd0, lsu_done, lsu_stall}, 0);
  endtask
  initial begin
    logic [31:0] m;
    #2;
    idle_outputs("reset");
    tick();
    rst = 1'b0;
    tick();
    idle_outputs("idle");
    run(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    run(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
    run(1, 3'b001, 32'h102, 32'h00001234, 0, 2, 0);
    run(0, 3'b000, 32'h201, 0, 32'h80FF7F01, 0, 0);
    run(0, 3'b000, 32'h203, 0, 32'h80FF7F01, 1, 2);
    run(0, 3'b100, 32'h203, 0, 32'h80FF7F01, 0, 1);
    run(0, 3'b001, 32'h202, 0, 32'h80FF7F01, 0, 0);
    run(0, 3'b101, 32'h202, 0, 32'h80FF7F01, 3, 0);
    run(0, 3'b010, 32'h202, 0, 32'h80FF7F01, 0, 0);
    run(1, 3'b001, 32'h101, 32'h1234, 0, 0, 0);
    run(1, 3'b100, 32'h100, 32'h1234, 0, 0, 0);
    run(0, 3'b011, 32'h100, 0, 32'h1, 0, 0);
    run(0, 3'b010, 32'h300, 0, 32'h12345678, 100, 0);
    bus_rvalid = 1'b1;
    tick();
    chk("late_rvalid_done", {31'd0, lsu_done}, 0);
    bus_rvalid = 1'b0;
    tick();
    chk("late_rvalid_idle", {30'd0, lsu_done, lsu_stall}, 0);
    run(1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 0, 0);
    // Asynchronous reset while waiting in RESP.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_f3 = 3'b010; lsu_addr = 32'h200; bus_rdata = 32'h55AA55AA;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    tick();
    chk("resp_stall", {31'd0, lsu_stall}, 1);
    #2 rst = 1'b1;
    #1;
    idle_outputs("async_rst");
    lsu_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_outputs("after_rst");
    end
    run(0, 3'b010, 32'h200, 0, 32'h55AA55AA, 0, 0);
    for (int i = 0; i < 40; i++) begin
      m = $urandom;
      run(1'($urandom % 2), 3'($urandom % 8), 32'h400 + 32'($urandom % 64), $urandom, m,
          int'($urandom % 4), int'($urandom % 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
